// File: rtl/midi_in_parser.sv
// MIDI IN receiver: oversampled 8N1 byte recovery plus running-status message assembly.
// Real-time bytes are filtered out, SysEx is skipped, and channel messages come out with a one-cycle valid strobe.
module midi_in_parser #(
  parameter int BAUD_CNT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       frame_err
);
  localparam int CW = $clog2(BAUD_CNT);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_CNT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  logic          sync1_q, rx_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  logic          rs_valid_q, rs_valid_d;
  logic [7:0]    rs_q, rs_d;
  logic          need2_q, need2_d;
  logic [1:0]    dcnt_q, dcnt_d;
  logic [7:0]    hold1_q, hold1_d;
  logic          sysex_q, sysex_d;
  logic          msg_valid_q, msg_valid_d;
  logic [7:0]    msg_status_q, msg_status_d;
  logic [7:0]    msg_data1_q, msg_data1_d;
  logic [7:0]    msg_data2_q, msg_data2_d;
  logic [1:0]    msg_len_q, msg_len_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= midi_rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Leaving IDLE loads 1 so the counter equals the cycle index from the first low sample.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = CW'(1);
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = rx_s_q ? S_IDLE : S_BREAK;
          byte_valid_d = rx_s_q;
          frame_err_d  = !rx_s_q;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Real-time bytes (F8-FF) match no branch and leave the parser untouched.
  always_comb begin
    rs_valid_d   = rs_valid_q;
    rs_d         = rs_q;
    need2_d      = need2_q;
    dcnt_d       = dcnt_q;
    hold1_d      = hold1_q;
    sysex_d      = sysex_q;
    msg_valid_d  = 1'b0;
    msg_status_d = msg_status_q;
    msg_data1_d  = msg_data1_q;
    msg_data2_d  = msg_data2_q;
    msg_len_d    = msg_len_q;
    if (byte_valid_q) begin
      if (shift_q == 8'hF0) begin
        sysex_d    = 1'b1;
        rs_valid_d = 1'b0;
      end else if (shift_q >= 8'hF1 && shift_q <= 8'hF7) begin
        sysex_d    = 1'b0;
        rs_valid_d = 1'b0;
      end else if (shift_q >= 8'h80 && shift_q <= 8'hEF) begin
        rs_d       = shift_q;
        rs_valid_d = 1'b1;
        sysex_d    = 1'b0;
        need2_d    = (shift_q[7:5] != 3'b110);
        dcnt_d     = '0;
        hold1_d    = '0;
      end else if (!shift_q[7] && !sysex_q && rs_valid_q) begin
        if (dcnt_q == 2'd0) hold1_d = shift_q;
        if (need2_q && dcnt_q == 2'd0) begin
          dcnt_d = 2'd1;
        end else begin
          dcnt_d       = '0;
          msg_valid_d  = 1'b1;
          msg_status_d = rs_q;
          if (need2_q) begin
            msg_data1_d = hold1_q;
            msg_data2_d = shift_q;
            msg_len_d   = 2'd3;
          end else begin
            msg_data1_d = shift_q;
            msg_data2_d = 8'h00;
            msg_len_d   = 2'd2;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_valid_q   <= 1'b0;
      rs_q         <= '0;
      need2_q      <= 1'b1;
      dcnt_q       <= '0;
      hold1_q      <= '0;
      sysex_q      <= 1'b0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= '0;
      msg_data1_q  <= '0;
      msg_data2_q  <= '0;
      msg_len_q    <= '0;
    end else begin
      rs_valid_q   <= rs_valid_d;
      rs_q         <= rs_d;
      need2_q      <= need2_d;
      dcnt_q       <= dcnt_d;
      hold1_q      <= hold1_d;
      sysex_q      <= sysex_d;
      msg_valid_q  <= msg_valid_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      msg_len_q    <= msg_len_d;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_status = msg_status_q;
  assign msg_data1  = msg_data1_q;
  assign msg_data2  = msg_data2_q;
  assign msg_len    = msg_len_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_midi_in_parser.sv
// Scoreboard bench for midi_in_parser: serial frames are driven on midi_rx, a byte-level
// MIDI model predicts messages, and a monitor compares each msg_valid against the queue.
module tb_midi_in_parser;
  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       midi_rx = 1'b1;
  logic       msg_valid, frame_err;
  logic [7:0] msg_status, msg_data1, msg_data2;
  logic [1:0] msg_len;

  midi_in_parser #(.BAUD_CNT(B)) dut (
    .clk(clk), .rst(rst_n), .midi_rx(midi_rx),
    .msg_valid(msg_valid), .msg_status(msg_status), .msg_data1(msg_data1),
    .msg_data2(msg_data2), .msg_len(msg_len), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  msg_t exp_q[$];
  msg_t last_exp;
  msg_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   fer_exp = 0;
  int   fer_seen = 0;

  // Byte-level MIDI model state.
  int   m_rs = -1;
  bit   m_sysex = 1'b0;
  int   m_dat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_rs = -1;
    m_sysex = 1'b0;
    m_dat.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int   need;
    msg_t m;
    if (b >= 8'hF8) return;
    if (b == 8'hF0) begin m_sysex = 1'b1; m_rs = -1; return; end
    if (b > 8'hF0) begin m_sysex = 1'b0; m_rs = -1; return; end
    if (b >= 8'h80) begin m_rs = int'(b); m_sysex = 1'b0; m_dat.delete(); return; end
    if (m_sysex || m_rs < 0) return;
    m_dat.push_back(int'(b));
    need = (m_rs >= 'hC0 && m_rs <= 'hDF) ? 1 : 2;
    if (m_dat.size() == need) begin
      m.st  = 8'(m_rs);
      m.d1  = 8'(m_dat[0]);
      m.d2  = (need == 2) ? 8'(m_dat[1]) : 8'h00;
      m.len = 2'(need + 1);
      exp_q.push_back(m);
      last_exp = m;
      m_dat.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fer_seen++;
      if (msg_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_msg: got %0h %0h %0h len %0d, no message expected",
                   msg_status, msg_data1, msg_data2, msg_len);
        end else begin
          mon_e = exp_q.pop_front();
          check("msg", 32'({msg_status, msg_data1, msg_data2, msg_len}), 32'(mon_e));
        end
      end
    end
  end

  // All drive tasks start and end on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    midi_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (B) @(negedge clk);
    end
    if (stop_ok) model_byte(b);
    else fer_exp++;
    midi_rx = stop_ok;
    repeat (B) @(negedge clk);
  endtask

  task automatic idle(input int n);
    midi_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_err_count"}, 32'(fer_seen), 32'(fer_exp));
  endtask

  task automatic check_zero(input string name);
    check({name, "_valid"}, 32'(msg_valid), 32'd0);
    check({name, "_ferr"}, 32'(frame_err), 32'd0);
    check({name, "_status"}, 32'(msg_status), 32'd0);
    check({name, "_d1"}, 32'(msg_data1), 32'd0);
    check({name, "_d2"}, 32'(msg_data2), 32'd0);
    check({name, "_len"}, 32'(msg_len), 32'd0);
  endtask

  task automatic check_hold(input string name);
    check(name, 32'({msg_status, msg_data1, msg_data2, msg_len}), 32'(last_exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bt;
    int r;
    rst_n = 1'b0;
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(5);

    send_byte(8'hB0, 1'b1); send_byte(8'h2E, 1'b1); send_byte(8'h7F, 1'b1);
    idle(30);
    drain("cc");
    check_hold("cc_hold");

    send_byte(8'hC0, 1'b1); send_byte(8'h42, 1'b1); send_byte(8'h43, 1'b1);
    idle(10);
    drain("pc_running");
    check_hold("pc_hold");

    send_byte(8'h90, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h3C, 1'b1);
    send_byte(8'hFE, 1'b1); send_byte(8'h40, 1'b1);
    idle(10);
    drain("realtime");

    send_byte(8'hF0, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'hF7, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
    idle(10);
    drain("sysex_skip");
    send_byte(8'h80, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
    idle(10);
    drain("after_sysex");
    check_hold("note_off_hold");

    send_byte(8'h55, 1'b0);
    midi_rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(10);
    drain("frame_err");
    send_byte(8'hB0, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1);
    idle(10);
    drain("after_break");
    check_hold("after_break_hold");

    midi_rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    drain("glitch");

    send_byte(8'hB0, 1'b1);
    bt = 8'h2E;
    midi_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      midi_rx = bt[i];
      repeat (B) @(negedge clk);
    end
    midi_rx = bt[3];
    repeat (B / 2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("midreset");
    midi_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_byte(8'hB0, 1'b1); send_byte(8'h2E, 1'b1); send_byte(8'h7F, 1'b1);
    idle(10);
    drain("after_reset");
    check_hold("after_reset_hold");

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      bt = 8'($urandom_range(8'h00, 8'h7F));
      else if (r < 75) bt = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 85) bt = 8'($urandom_range(8'hF8, 8'hFF));
      else if (r < 90) bt = 8'hF0;
      else             bt = 8'($urandom_range(8'hF1, 8'hF7));
      if ($urandom_range(0, 99) < 3) begin
        send_byte(bt, 1'b0);
        idle(6);
      end else begin
        send_byte(bt, 1'b1);
        idle(int'($urandom_range(0, 4)));
      end
    end
    idle(20);
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
